flash_fetch_arbiter: RTL and testbench

- Shares one quad-I/O flash line reader (EBh fast-read engine, 128-bit lines) between two line requesters: port 0 = instruction cache refill, port 1 = data/literal read path.
- Owns sequencing of the reader: one-cycle rd pulse, waits for done, registers the returned line, acknowledges the owning port, then enforces a minimum idle gap before the next transaction (CE high time).
- Sits between the cache controllers and the flash reader inside the XIP controller.

---
 rtl/flash_fetch_arbiter_if.sv | 28 ++
 rtl/flash_fetch_arbiter.sv | 113 +++++++++++
 tb/tb_flash_fetch_arbiter.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/flash_fetch_arbiter_if.sv
// Bundles the requester handshakes and the flash line reader handshake
// that pass through flash_fetch_arbiter.
interface flash_fetch_arbiter_if #(
    parameter int LINE_SIZE = 128
);
    logic                 req0;
    logic [23:0]          addr0;
    logic                 ack0;
    logic                 req1;
    logic [23:0]          addr1;
    logic                 ack1;
    logic [LINE_SIZE-1:0] line_o;
    logic                 busy;
    logic                 fr_rd;
    logic [23:0]          fr_addr;
    logic                 fr_done;
    logic [LINE_SIZE-1:0] fr_line;

    modport slave (
        input  req0, addr0, req1, addr1, fr_done, fr_line,
        output ack0, ack1, line_o, busy, fr_rd, fr_addr
    );

    modport master (
        output req0, addr0, req1, addr1, fr_done, fr_line,
        input  ack0, ack1, line_o, busy, fr_rd, fr_addr
    );
endinterface

// File: rtl/flash_fetch_arbiter.sv
// Round-robin arbiter sharing one quad-I/O flash line reader between the
// instruction refill port (0) and the data/literal port (1).
module flash_fetch_arbiter #(
    parameter int LINE_SIZE  = 128,
    parameter int GAP_CYCLES = 2
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    flash_fetch_arbiter_if.slave  bus
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_BUSY  = 2'd2;
    localparam logic [1:0] ST_GAP   = 2'd3;

    localparam logic [3:0] GAP_LOAD = 4'(GAP_CYCLES - 1);

    logic [1:0]           state_r;
    logic                 owner_r;
    logic                 rr_last_r;
    logic                 fr_rd_r;
    logic                 ack0_r;
    logic                 ack1_r;
    logic                 busy_r;
    logic [23:0]          fr_addr_r;
    logic [LINE_SIZE-1:0] line_r;
    logic [3:0]           gap_cnt_r;

    logic                 req_any_s;
    logic                 grant_s;
    logic [23:0]          grant_addr_s;

    // Pick the next owner: a sole requester wins, a tie goes to the port not served last.
    always_comb begin
        req_any_s = bus.req0 | bus.req1;
        if (bus.req0 && bus.req1) begin
            grant_s = ~rr_last_r;
        end else if (bus.req1) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
        if (grant_s) begin
            grant_addr_s = bus.addr1;
        end else begin
            grant_addr_s = bus.addr0;
        end
    end

    // Transaction sequencer: grant, rd pulse, wait for the line, ack, then CE-high gap.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_r   <= ST_IDLE;
            owner_r   <= 1'b0;
            rr_last_r <= 1'b1;
            fr_rd_r   <= 1'b0;
            ack0_r    <= 1'b0;
            ack1_r    <= 1'b0;
            busy_r    <= 1'b0;
            fr_addr_r <= 24'h00_0000;
            line_r    <= '0;
            gap_cnt_r <= 4'd0;
        end else begin
            fr_rd_r <= 1'b0;
            ack0_r  <= 1'b0;
            ack1_r  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (req_any_s) begin
                        owner_r   <= grant_s;
                        rr_last_r <= grant_s;
                        fr_addr_r <= {grant_addr_s[23:4], 4'h0};
                        fr_rd_r   <= 1'b1;
                        busy_r    <= 1'b1;
                        state_r   <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    state_r <= ST_BUSY;
                end
                ST_BUSY: begin
                    if (bus.fr_done) begin
                        line_r    <= bus.fr_line;
                        ack0_r    <= ~owner_r;
                        ack1_r    <= owner_r;
                        gap_cnt_r <= GAP_LOAD;
                        state_r   <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    // The ack cycle is the first gap cycle, so IDLE arrives GAP_CYCLES after it.
                    if (gap_cnt_r == 4'd0) begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end else begin
                        gap_cnt_r <= gap_cnt_r - 4'd1;
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.fr_rd   = fr_rd_r;
    assign bus.fr_addr = fr_addr_r;
    assign bus.ack0    = ack0_r;
    assign bus.ack1    = ack1_r;
    assign bus.line_o  = line_r;
    assign bus.busy    = busy_r;
endmodule

// File: tb/tb_flash_fetch_arbiter.sv
// Directed bench for flash_fetch_arbiter: a GAP_CYCLES=2 instance plus a
// GAP_CYCLES=1 instance, with the flash reader modelled by the bench.
module tb_flash_fetch_arbiter;
    logic HCLK;
    logic HRESET;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    localparam logic [127:0] LINE_A = {4{32'hA5A5_A5A5}};
    localparam logic [127:0] LINE_1 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    localparam logic [127:0] LINE_2 = 128'h9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0000;
    localparam logic [127:0] LINE_3 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [127:0] LINE_4 = 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF;
    localparam logic [127:0] LINE_5 = 128'hC0FF_EE00_C0FF_EE00_C0FF_EE00_C0FF_EE00;
    localparam logic [127:0] LINE_6 = 128'h5A5A_5A5A_0F0F_0F0F_F0F0_F0F0_A5A5_A5A5;

    flash_fetch_arbiter_if #(.LINE_SIZE(128)) bus0 ();
    flash_fetch_arbiter_if #(.LINE_SIZE(128)) bus1 ();

    flash_fetch_arbiter #(.LINE_SIZE(128), .GAP_CYCLES(2)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .bus(bus0)
    );
    flash_fetch_arbiter #(.LINE_SIZE(128), .GAP_CYCLES(1)) dut_g1 (
        .HCLK(HCLK), .HRESET(HRESET), .bus(bus1)
    );

    initial begin
        HCLK = 1'b0;
        forever #5 HCLK = ~HCLK;
    end

    always @(posedge HCLK) cyc <= cyc + 1;

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic done0(input logic [127:0] l);
        bus0.fr_line = l;
        bus0.fr_done = 1'b1;
        tick();
        bus0.fr_done = 1'b0;
        bus0.fr_line = '0;
    endtask

    task automatic wait_rd0(output int n_ticks, output int n_idle, output bit timeout);
        n_ticks = 0;
        n_idle  = 0;
        timeout = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            n_ticks++;
            if (bus0.fr_rd === 1'b1) begin
                timeout = 1'b0;
                break;
            end
            if (bus0.busy === 1'b0) n_idle++;
        end
    endtask

    task automatic test_reset();
        HRESET = 1'b1;
        tick();
        tick();
        checks++; if (bus0.ack0 !== 1'b0 || bus0.ack1 !== 1'b0) begin failures++; $display("FAIL reset_ack: got %b%b want 00", bus0.ack1, bus0.ack0); end
        checks++; if (bus0.busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", bus0.busy); end
        checks++; if (bus0.fr_rd !== 1'b0) begin failures++; $display("FAIL reset_rd: got %b want 0", bus0.fr_rd); end
        checks++; if (bus0.fr_addr !== 24'h000000) begin failures++; $display("FAIL reset_addr: got %h want 000000", bus0.fr_addr); end
        checks++; if (bus0.line_o !== 128'h0) begin failures++; $display("FAIL reset_line: got %h want 0", bus0.line_o); end
        checks++; if (bus1.busy !== 1'b0 || bus1.fr_rd !== 1'b0) begin failures++; $display("FAIL reset_g1: got busy=%b rd=%b want 0 0", bus1.busy, bus1.fr_rd); end
        HRESET = 1'b0;
    endtask

    task automatic test_single();
        bus0.req0  = 1'b1;
        bus0.addr0 = 24'h012345;
        tick();
        checks++; if (bus0.fr_rd !== 1'b1) begin failures++; $display("FAIL single_rd: got %b want 1", bus0.fr_rd); end
        checks++; if (bus0.fr_addr !== 24'h012340) begin failures++; $display("FAIL single_addr: got %h want 012340", bus0.fr_addr); end
        tick();
        checks++; if (bus0.fr_rd !== 1'b0 || bus0.busy !== 1'b1) begin failures++; $display("FAIL single_busy: got rd=%b busy=%b want 0 1", bus0.fr_rd, bus0.busy); end
        tick();
        done0(LINE_A);
        checks++; if (bus0.ack0 !== 1'b1 || bus0.ack1 !== 1'b0) begin failures++; $display("FAIL single_ack: got %b%b want 01", bus0.ack1, bus0.ack0); end
        checks++; if (bus0.line_o !== LINE_A) begin failures++; $display("FAIL single_line: got %h want %h", bus0.line_o, LINE_A); end
        bus0.req0 = 1'b0;
        tick();
        checks++; if (bus0.ack0 !== 1'b0 || bus0.busy !== 1'b1) begin failures++; $display("FAIL single_gap: got ack0=%b busy=%b want 0 1", bus0.ack0, bus0.busy); end
        tick();
        checks++; if (bus0.busy !== 1'b0 || bus0.line_o !== LINE_A) begin failures++; $display("FAIL single_idle: got busy=%b line=%h want 0 %h", bus0.busy, bus0.line_o, LINE_A); end
    endtask

    task automatic test_tie();
        int  ack_cyc, nt, ni;
        bit  to;
        HRESET = 1'b1;
        tick();
        HRESET = 1'b0;
        bus0.req0  = 1'b1;
        bus0.addr0 = 24'h000100;
        bus0.req1  = 1'b1;
        bus0.addr1 = 24'h000200;
        tick();
        checks++; if (bus0.fr_rd !== 1'b1 || bus0.fr_addr !== 24'h000100) begin failures++; $display("FAIL tie_first: got rd=%b addr=%h want 1 000100", bus0.fr_rd, bus0.fr_addr); end
        tick();
        done0(LINE_1);
        ack_cyc = cyc;
        checks++; if (bus0.ack0 !== 1'b1 || bus0.ack1 !== 1'b0 || bus0.line_o !== LINE_1) begin failures++; $display("FAIL tie_ack0: got %b%b line=%h want 01 %h", bus0.ack1, bus0.ack0, bus0.line_o, LINE_1); end
        bus0.req0 = 1'b0;
        wait_rd0(nt, ni, to);
        checks++; if (to || (cyc - ack_cyc) != 3) begin failures++; $display("FAIL tie_second_rd: got timeout=%0d delay=%0d want 0 3", to, cyc - ack_cyc); end
        checks++; if (bus0.fr_addr !== 24'h000200) begin failures++; $display("FAIL tie_second_addr: got %h want 000200", bus0.fr_addr); end
        tick();
        done0(LINE_2);
        checks++; if (bus0.ack1 !== 1'b1 || bus0.ack0 !== 1'b0 || bus0.line_o !== LINE_2) begin failures++; $display("FAIL tie_ack1: got %b%b line=%h want 10 %h", bus0.ack1, bus0.ack0, bus0.line_o, LINE_2); end
        bus0.req1 = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_alternate();
        int            nt, ni;
        bit            to;
        logic          exp_owner;
        logic [127:0]  l;
        bus0.req0  = 1'b1;
        bus0.addr0 = 24'h00ABCD;
        bus0.req1  = 1'b1;
        bus0.addr1 = 24'h00FFFF;
        for (int i = 0; i < 6; i++) begin
            exp_owner = (i % 2) == 1;
            wait_rd0(nt, ni, to);
            checks++; if (to || bus0.fr_addr !== (exp_owner ? 24'h00FFF0 : 24'h00ABC0)) begin failures++; $display("FAIL alt_addr_%0d: got timeout=%0d addr=%h want owner %0d", i, to, bus0.fr_addr, exp_owner); end
            if (i > 0) begin
                checks++; if (ni != 1) begin failures++; $display("FAIL alt_idle_%0d: got %0d idle cycles want 1", i, ni); end
            end
            tick();
            l = {16{8'(i + 1)}};
            done0(l);
            checks++; if ({bus0.ack1, bus0.ack0} !== (exp_owner ? 2'b10 : 2'b01) || bus0.line_o !== l) begin failures++; $display("FAIL alt_ack_%0d: got %b%b line=%h want owner %0d", i, bus0.ack1, bus0.ack0, bus0.line_o, exp_owner); end
        end
        bus0.req0 = 1'b0;
        bus0.req1 = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_drop();
        int rd_cnt;
        bus0.req1  = 1'b1;
        bus0.addr1 = 24'h00030F;
        tick();
        checks++; if (bus0.fr_rd !== 1'b1 || bus0.fr_addr !== 24'h000300) begin failures++; $display("FAIL drop_rd: got rd=%b addr=%h want 1 000300", bus0.fr_rd, bus0.fr_addr); end
        bus0.req1 = 1'b0;
        tick();
        tick();
        done0(LINE_3);
        checks++; if (bus0.ack1 !== 1'b1 || bus0.ack0 !== 1'b0 || bus0.line_o !== LINE_3) begin failures++; $display("FAIL drop_ack: got %b%b line=%h want 10 %h", bus0.ack1, bus0.ack0, bus0.line_o, LINE_3); end
        rd_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus0.fr_rd === 1'b1) rd_cnt++;
        end
        checks++; if (rd_cnt != 0 || bus0.busy !== 1'b0) begin failures++; $display("FAIL drop_no_reissue: got rd_count=%0d busy=%b want 0 0", rd_cnt, bus0.busy); end
    endtask

    task automatic test_reset_busy();
        bus0.req0  = 1'b1;
        bus0.addr0 = 24'h000400;
        tick();
        bus0.req0 = 1'b0;
        tick();
        checks++; if (bus0.busy !== 1'b1) begin failures++; $display("FAIL rstb_pre: got busy=%b want 1", bus0.busy); end
        HRESET = 1'b1;
        tick();
        HRESET = 1'b0;
        checks++; if ({bus0.ack1, bus0.ack0, bus0.busy, bus0.fr_rd} !== 4'b0000 || bus0.fr_addr !== 24'h000000 || bus0.line_o !== 128'h0) begin
            failures++; $display("FAIL rstb_outputs: got ack=%b%b busy=%b rd=%b addr=%h line=%h want all 0", bus0.ack1, bus0.ack0, bus0.busy, bus0.fr_rd, bus0.fr_addr, bus0.line_o);
        end
        done0(LINE_4);
        checks++; if (bus0.ack0 !== 1'b0 || bus0.ack1 !== 1'b0 || bus0.line_o !== 128'h0 || bus0.busy !== 1'b0) begin failures++; $display("FAIL rstb_stray_done: got ack=%b%b busy=%b line=%h want 0", bus0.ack1, bus0.ack0, bus0.busy, bus0.line_o); end
    endtask

    task automatic test_gap1();
        bus1.req0  = 1'b1;
        bus1.addr0 = 24'h000555;
        tick();
        checks++; if (bus1.fr_rd !== 1'b1 || bus1.fr_addr !== 24'h000550) begin failures++; $display("FAIL g1_rd: got rd=%b addr=%h want 1 000550", bus1.fr_rd, bus1.fr_addr); end
        tick();
        bus1.fr_line = LINE_5;
        bus1.fr_done = 1'b1;
        tick();
        bus1.fr_done = 1'b0;
        checks++; if (bus1.ack0 !== 1'b1 || bus1.line_o !== LINE_5) begin failures++; $display("FAIL g1_ack: got ack0=%b line=%h want 1 %h", bus1.ack0, bus1.line_o, LINE_5); end
        bus1.req0 = 1'b0;
        tick();
        checks++; if (bus1.busy !== 1'b0 || bus1.fr_rd !== 1'b0) begin failures++; $display("FAIL g1_idle: got busy=%b rd=%b want 0 0", bus1.busy, bus1.fr_rd); end
        bus1.req0  = 1'b1;
        bus1.addr0 = 24'h000560;
        tick();
        checks++; if (bus1.fr_rd !== 1'b1 || bus1.fr_addr !== 24'h000560) begin failures++; $display("FAIL g1_second_rd: got rd=%b addr=%h want 1 000560", bus1.fr_rd, bus1.fr_addr); end
        bus1.req0 = 1'b0;
        tick();
        tick();
        checks++; if (bus1.fr_rd !== 1'b0 || bus1.busy !== 1'b1) begin failures++; $display("FAIL g1_no_overlap: got rd=%b busy=%b want 0 1", bus1.fr_rd, bus1.busy); end
        bus1.fr_line = LINE_6;
        bus1.fr_done = 1'b1;
        tick();
        bus1.fr_done = 1'b0;
        checks++; if (bus1.ack0 !== 1'b1 || bus1.line_o !== LINE_6) begin failures++; $display("FAIL g1_ack2: got ack0=%b line=%h want 1 %h", bus1.ack0, bus1.line_o, LINE_6); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        HRESET       = 1'b1;
        bus0.req0    = 1'b0;
        bus0.addr0   = 24'h000000;
        bus0.req1    = 1'b0;
        bus0.addr1   = 24'h000000;
        bus0.fr_done = 1'b0;
        bus0.fr_line = '0;
        bus1.req0    = 1'b0;
        bus1.addr0   = 24'h000000;
        bus1.req1    = 1'b0;
        bus1.addr1   = 24'h000000;
        bus1.fr_done = 1'b0;
        bus1.fr_line = '0;
        test_reset();
        test_single();
        test_tie();
        test_alternate();
        test_drop();
        test_reset_busy();
        test_gap1();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
